rom_load_ctrl: RTL

//  Sequences HPS ROM download (ioctl, index 0) into the game's ROM write ports. Decodes
//  the linear download address into three regions (CPU ROM, gfx ROM, colour PROM), paces

---
 rtl/rom_load_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rom_load_ctrl.sv
// Sequences HPS ioctl ROM downloads (index 0) into three region write ports and holds the game in reset.
// Optional feature: define ROM_LOAD_CHECKSUM_EN to keep an additive checksum of written bytes.
module rom_load_ctrl #(
    parameter int          ADDR_W   = 14,
    parameter logic [24:0] R0_END   = 25'h1FFF,
    parameter logic [24:0] R1_END   = 25'h27FF,
    parameter logic [24:0] R2_END   = 25'h281F,
    parameter int          WR_GAP   = 4,
    parameter int          RST_HOLD = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [2:0]        rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              game_reset,
    output logic              load_done,
    output logic              overflow_err,
    output logic [7:0]        checksum
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, GAP, HOLD, RUN} state_t;

    localparam int GAP_W  = $clog2(WR_GAP + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    localparam logic [2:0][24:0] END_TAB  = {R2_END, R1_END, R0_END};
    localparam logic [2:0][24:0] BASE_TAB = {25'(R1_END + 25'd1), 25'(R0_END + 25'd1), 25'd0};

    state_t              state_reg;
    logic [GAP_W-1:0]    gap_cnt_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [2:0]          hit;
    logic [24:0]         base_sel;
    logic                active;

    assign active = ioctl_download && (ioctl_index == 8'd0);

    // Regions are contiguous: each one starts just above the previous one's end.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_region
            if (gi == 0) begin : g_first
                assign hit[gi] = (ioctl_addr <= END_TAB[gi]);
            end else begin : g_rest
                assign hit[gi] = (ioctl_addr > END_TAB[gi-1]) && (ioctl_addr <= END_TAB[gi]);
            end
        end
    endgenerate

    always_comb begin
        base_sel = BASE_TAB[2];
        if (hit[0])
            base_sel = BASE_TAB[0];
        else if (hit[1])
            base_sel = BASE_TAB[1];
    end

`ifdef ROM_LOAD_CHECKSUM_EN
    logic [7:0] checksum_reg;
    assign checksum = checksum_reg;
`else
    assign checksum = 8'h00;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg    <= IDLE;
            gap_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            ioctl_wait   <= 1'b0;
            rom_we       <= 3'b000;
            rom_addr     <= '0;
            rom_data     <= 8'h00;
            game_reset   <= 1'b1;
            load_done    <= 1'b0;
            overflow_err <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
            checksum_reg <= 8'h00;
`endif
        end else begin
            case (state_reg)
                IDLE, RUN: begin
                    if (active) begin
                        state_reg    <= LOAD;
                        game_reset   <= 1'b1;
                        load_done    <= 1'b0;
                        overflow_err <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
                        checksum_reg <= 8'h00;
`endif
                    end
                end
                LOAD: begin
                    if (!active) begin
                        state_reg    <= HOLD;
                        hold_cnt_reg <= '0;
                    end else if (ioctl_wr) begin
                        state_reg  <= WRITE;
                        ioctl_wait <= 1'b1;
                        rom_we     <= hit;
                        rom_addr   <= ADDR_W'(ioctl_addr - base_sel);
                        rom_data   <= ioctl_dout;
                    end
                end
                WRITE: begin
                    rom_we <= 3'b000;
                    // A strobe-less write cycle means the byte fell outside every region.
                    if (rom_we == 3'b000)
                        overflow_err <= 1'b1;
`ifdef ROM_LOAD_CHECKSUM_EN
                    if (rom_we != 3'b000)
                        checksum_reg <= checksum_reg + rom_data;
`endif
                    if (WR_GAP <= 1) begin
                        ioctl_wait   <= 1'b0;
                        state_reg    <= active ? LOAD : HOLD;
                        hold_cnt_reg <= '0;
                    end else begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_W'(WR_GAP - 2)) begin
                        ioctl_wait   <= 1'b0;
                        state_reg    <= active ? LOAD : HOLD;
                        hold_cnt_reg <= '0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                HOLD: begin
                    if (active) begin
                        state_reg    <= LOAD;
                        overflow_err <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
                        checksum_reg <= 8'h00;
`endif
                    end else if (hold_cnt_reg == HOLD_W'(RST_HOLD - 1)) begin
                        state_reg  <= RUN;
                        game_reset <= 1'b0;
                        load_done  <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
